// File: rtl/pic_priority_inta_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pic_priority_inta_ctrl_if
//  Description : Bus bundle between the 8259 request register / CPU side and
//                the priority resolver / INTA sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pic_priority_inta_ctrl_if;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] icw2_base;
    logic       aeoi;
    logic       inta;
    logic       eoi;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       eoi_rotate;
    logic       int_out;
    logic [2:0] highest_priority_idx;
    logic       ack_clr;
    logic [7:0] isr;
    logic [7:0] vector_out;
    logic       vector_valid;

    // Request register / CPU side
    modport master (
        output irr, imr, icw2_base, aeoi, inta, eoi, eoi_specific, eoi_level, eoi_rotate,
        input  int_out, highest_priority_idx, ack_clr, isr, vector_out, vector_valid
    );

    // Priority resolver side
    modport slave (
        input  irr, imr, icw2_base, aeoi, inta, eoi, eoi_specific, eoi_level, eoi_rotate,
        output int_out, highest_priority_idx, ack_clr, isr, vector_out, vector_valid
    );
endinterface
`default_nettype wire

// File: rtl/pic_priority_inta_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pic_priority_inta_ctrl
//  Description : 8259 priority resolver, in-service register, INT generation,
//                two-pulse INTA sequencing, EOI handling and rotating priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_priority_inta_ctrl #(
    parameter int N_IRQ          = 8,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  wire logic               clk,
    input  wire logic               reset,
    pic_priority_inta_ctrl_if.slave bus
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_WAIT2 = 1'b1;
    localparam logic [2:0] c_SPUR_IDX = 3'(SPURIOUS_LEVEL);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;

    logic [2:0] r_lowest_prio;
    logic [7:0] r_isr;
    logic       r_int_out;
    logic       r_ack_clr;
    logic [2:0] r_idx;
    logic       r_spur;
    logic [7:0] r_vector;
    logic       r_vector_valid;

    logic [7:0] w_req;
    logic       w_cand_vld;
    logic [2:0] w_cand_idx;
    logic [2:0] w_cand_rank;
    logic       w_isr_vld;
    logic [2:0] w_isr_idx;
    logic [2:0] w_isr_rank;
    logic       w_pend;
    logic [2:0] w_pos;

    logic [7:0] w_eoi_clr;
    logic       w_rot_en;
    logic [2:0] w_rot_level;

    logic       w_int_nxt;
    logic       w_ack_nxt;
    logic [2:0] w_idx_nxt;
    logic       w_spur_nxt;
    logic [7:0] w_vec_nxt;
    logic       w_vv_nxt;
    logic [7:0] w_set;
    logic [7:0] w_aeoi_clr;

    assign w_req = bus.irr & ~bus.imr;

    // Scan levels from lowest rank to highest so the highest-ranked hit wins,
    // for both the unmasked requests and the in-service bits.
    always_comb begin
        w_cand_vld  = 1'b0;
        w_cand_idx  = 3'd0;
        w_cand_rank = 3'd0;
        w_isr_vld   = 1'b0;
        w_isr_idx   = 3'd0;
        w_isr_rank  = 3'd0;
        w_pos       = 3'd0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            w_pos = r_lowest_prio + 3'd1 + 3'(k);
            if (w_req[w_pos]) begin
                w_cand_vld  = 1'b1;
                w_cand_idx  = w_pos;
                w_cand_rank = 3'(k);
            end
            if (r_isr[w_pos]) begin
                w_isr_vld  = 1'b1;
                w_isr_idx  = w_pos;
                w_isr_rank = 3'(k);
            end
        end
    end

    // A request interrupts only if it outranks everything already in service.
    assign w_pend = w_cand_vld && (!w_isr_vld || (w_cand_rank < w_isr_rank));

    // EOI decode: which ISR bit to clear and whether priority rotates.
    always_comb begin
        w_eoi_clr   = 8'd0;
        w_rot_en    = 1'b0;
        w_rot_level = r_lowest_prio;
        if (bus.eoi) begin
            if (bus.eoi_specific) begin
                w_eoi_clr   = 8'd1 << bus.eoi_level;
                w_rot_en    = bus.eoi_rotate;
                w_rot_level = bus.eoi_level;
            end else if (w_isr_vld) begin
                w_eoi_clr   = 8'd1 << w_isr_idx;
                w_rot_en    = bus.eoi_rotate;
                w_rot_level = w_isr_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: each INTA pulse advances the two-step sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.inta) w_state_nxt = c_ST_WAIT2;
            c_ST_WAIT2: if (bus.inta) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and ISR set/clear masks.
    always_comb begin
        w_int_nxt  = 1'b0;
        w_ack_nxt  = 1'b0;
        w_idx_nxt  = r_idx;
        w_spur_nxt = r_spur;
        w_vec_nxt  = r_vector;
        w_vv_nxt   = 1'b0;
        w_set      = 8'd0;
        w_aeoi_clr = 8'd0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.inta) begin
                    // A request that vanished before the first INTA is spurious.
                    w_idx_nxt  = w_pend ? w_cand_idx : c_SPUR_IDX;
                    w_spur_nxt = !w_pend;
                    w_ack_nxt  = 1'b1;
                    if (w_pend) begin
                        w_set = 8'd1 << w_cand_idx;
                    end
                end else begin
                    w_int_nxt = w_pend;
                end
            end
            c_ST_WAIT2: begin
                if (bus.inta) begin
                    w_vec_nxt = {bus.icw2_base, r_idx};
                    w_vv_nxt  = 1'b1;
                    if (bus.aeoi && !r_spur) begin
                        w_aeoi_clr = 8'd1 << r_idx;
                    end
                end
            end
            default: ;
        endcase
    end

    // Register outputs, ISR and rotation pointer; a set beats a clear on the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lowest_prio  <= 3'd7;
            r_isr          <= 8'd0;
            r_int_out      <= 1'b0;
            r_ack_clr      <= 1'b0;
            r_idx          <= 3'd0;
            r_spur         <= 1'b0;
            r_vector       <= 8'd0;
            r_vector_valid <= 1'b0;
        end else begin
            r_isr          <= (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_set;
            r_int_out      <= w_int_nxt;
            r_ack_clr      <= w_ack_nxt;
            r_idx          <= w_idx_nxt;
            r_spur         <= w_spur_nxt;
            r_vector       <= w_vec_nxt;
            r_vector_valid <= w_vv_nxt;
            if (w_rot_en) begin
                r_lowest_prio <= w_rot_level;
            end
        end
    end

    assign bus.int_out              = r_int_out;
    assign bus.ack_clr              = r_ack_clr;
    assign bus.highest_priority_idx = r_idx;
    assign bus.isr                  = r_isr;
    assign bus.vector_out           = r_vector;
    assign bus.vector_valid         = r_vector_valid;

endmodule
`default_nettype wire
